pc_control: RTL

Program-counter and branch-resolution stage for the single-cycle WISC processor. Sits directly downstream of the 16-bit adder datapath: consumes the ALU result flags, holds the architectural flag register (Z, V, N), and produces the next PC from PC+2, a PC-relative branch target, or a register target. Owns the RUN/HALTED state and the stall freeze.

---
 rtl/pc_control.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pc_control.sv
// pc_control: program-counter and branch-resolution stage for the
// single-cycle WISC core. Holds the architectural Z/V/N flags and picks the
// next PC from PC+2, a PC-relative branch target or a register target.
// It also owns the RUN/HALTED state and the stall freeze.
module pc_control #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        halt,
  input  logic        br_en,
  input  logic        br_reg,
  input  logic [2:0]  ccc,
  input  logic [8:0]  imm9,
  input  logic [15:0] reg_target,
  input  logic [2:0]  flag_wr,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        alu_n,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        taken,
  output logic [2:0]  flags,
  output logic        halted
);

  // Branch condition codes
  localparam logic [2:0] CC_NE   = 3'b000;
  localparam logic [2:0] CC_EQ   = 3'b001;
  localparam logic [2:0] CC_GT   = 3'b010;
  localparam logic [2:0] CC_LT   = 3'b011;
  localparam logic [2:0] CC_GTE  = 3'b100;
  localparam logic [2:0] CC_LTE  = 3'b101;
  localparam logic [2:0] CC_OVFL = 3'b110;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t      state;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;
  logic        cond_met;
  logic [15:0] b_offset;
  logic [15:0] b_target;
  logic [15:0] branch_pc;
  logic [2:0]  alu_flags;
  logic        flag_load;

  // Flag register layout is {Z,V,N}
  assign flag_z    = flags[2];
  assign flag_v    = flags[1];
  assign flag_n    = flags[0];
  assign alu_flags = {alu_z, alu_v, alu_n};

  // Sequential and PC-relative targets; carries out of bit 15 are dropped
  // so both wrap modulo 2^16.
  assign pc_plus2 = pc + 16'd2;
  assign b_offset = {{6{imm9[8]}}, imm9, 1'b0};
  assign b_target = pc_plus2 + b_offset;

  // Evaluate the branch condition against the registered flags only; a flag
  // write in the same cycle is not visible until the next one.
  always_comb begin
    cond_met = 1'b1;
    case (ccc)
      CC_NE:   cond_met = ~flag_z;
      CC_EQ:   cond_met = flag_z;
      CC_GT:   cond_met = ~flag_z & ~flag_n;
      CC_LT:   cond_met = flag_n;
      CC_GTE:  cond_met = flag_z | (~flag_z & ~flag_n);
      CC_LTE:  cond_met = flag_n | flag_z;
      CC_OVFL: cond_met = flag_v;
      default: cond_met = 1'b1;
    endcase
  end

  // taken is forced low while in reset and while halted
  assign taken = (br_en | br_reg) & cond_met & ~halted & rst_n;

  // Target select when the branch is taken: a register branch wins over a
  // PC-relative one if both are flagged.
  always_comb begin
    branch_pc = pc_plus2;
    if (taken && br_reg) begin
      branch_pc = reg_target;
    end else if (taken && br_en) begin
      branch_pc = b_target;
    end
  end

  // Flags only update while running and not stalled
  assign flag_load = (state == ST_RUN) & ~stall;

  // RUN/HALTED state machine with registered pc and halted outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_RUN;
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!stall) begin
            if (halt) begin
              // pc stays on the HLT instruction
              state  <= ST_HALTED;
              halted <= 1'b1;
            end else begin
              pc <= branch_pc;
            end
          end
        end
        ST_HALTED: begin
          // absorbing until reset
          state  <= ST_HALTED;
          halted <= 1'b1;
        end
        default: begin
          state  <= ST_RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // Per-bit flag register with independent write enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (flag_load && flag_wr[i]) begin
          flags[i] <= alu_flags[i];
        end
      end
    end
  end

endmodule
